mmu_systolic_array: RTL and testbench

// - MATRIX_WIDTH x MATRIX_WIDTH weight-stationary systolic MAC array: the TPU core datapath.
// - Double-buffered weights are loaded row by row, then activated. Skewed activation vectors stream in.
// - Each input vector x yields the deskewed row result[j] = sum_k x[k]*W[k][j].
// - Sits between the weight FIFO/unified buffer (inputs) and the accumulator bank (result).

---
 rtl/mmu_systolic_array.sv | 120 ++++++++++++
 tb/tb_mmu_systolic_array.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mmu_systolic_array.sv
// Weight-stationary MATRIX_WIDTH x MATRIX_WIDTH systolic MAC array with double-buffered weights.
// Optional macro MMU_OUTPUT_REG_EN adds one result register after the deskew stage (+1 cycle latency).
module mmu_systolic_array #(
  parameter int MATRIX_WIDTH = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [MATRIX_WIDTH-1:0][7:0]  weight_data,
  input  logic                          weight_signed,
  input  logic [7:0]                    weight_addr,
  input  logic                          load_weight,
  input  logic                          activate_weight,
  input  logic [MATRIX_WIDTH-1:0][7:0]  systolic_data,
  input  logic                          systolic_signed,
  output logic [MATRIX_WIDTH-1:0][31:0] result
);
  localparam int N = MATRIX_WIDTH;
  localparam int D = 2 * N - 2;

  logic [D:1]         diag;
  logic [D:0]         tok;
  logic signed [8:0]  a_pass [N][N];
  logic signed [31:0] ps     [N][N];
  logic [N-1:0][31:0] deskewed;

  // tok[s]: PEs on anti-diagonal s switch to the new weights at this enabled edge.
  // A new activation must wait until the previous ripple has reached diagonal D.
  assign tok = {diag, activate_weight};

  always_ff @(posedge clk) begin
    if (rst) diag <= '0;
    else if (enable) diag <= tok[D-1:0];
  end

  for (genvar k = 0; k < N; k++) begin : g_row
    assign a_pass[k][0] = {systolic_signed & systolic_data[k][7], systolic_data[k]};

    for (genvar j = 0; j < N; j++) begin : g_pe
      localparam int S = k + j;
      logic signed [8:0]  pre_q, snap_q, w_q, w_use;
      logic signed [17:0] prod;
      logic signed [31:0] sum_in, sum;

      // The switching PE bypasses the incoming weight so the vector entering at E already uses it
      assign w_use = tok[S] ? ((S == 0) ? pre_q : snap_q) : w_q;
      assign prod  = 18'(a_pass[k][j]) * 18'(w_use);

      if (k == 0) begin : g_top
        assign sum_in = '0;
      end else begin : g_mid
        assign sum_in = ps[k-1][j];
      end
      assign sum = sum_in + 32'(prod);

      always_ff @(posedge clk) begin
        if (rst) begin
          pre_q  <= '0;
          snap_q <= '0;
          w_q    <= '0;
        end else begin
          if (load_weight && weight_addr == 8'(k))
            pre_q <= {weight_signed & weight_data[j][7], weight_data[j]};
          if (enable && activate_weight) snap_q <= pre_q;
          if (enable && tok[S]) w_q <= w_use;
        end
      end

      if (j < N - 1) begin : g_fwd
        logic signed [8:0] a_q;
        always_ff @(posedge clk) begin
          if (rst) a_q <= '0;
          else if (enable) a_q <= a_pass[k][j];
        end
        assign a_pass[k][j+1] = a_q;
      end

      // Bottom row sum stays combinational to hit the array latency
      if (k < N - 1) begin : g_reg
        logic signed [31:0] ps_q;
        always_ff @(posedge clk) begin
          if (rst) ps_q <= '0;
          else if (enable) ps_q <= sum;
        end
        assign ps[k][j] = ps_q;
      end else begin : g_bot
        assign ps[k][j] = sum;
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_dsk
    localparam int L = N - 1 - j;
    if (L == 0) begin : g_direct
      assign deskewed[j] = ps[N-1][j];
    end else begin : g_delay
      logic [31:0] tap [L+1];
      assign tap[0] = ps[N-1][j];
      for (genvar m = 0; m < L; m++) begin : g_stage
        logic [31:0] q;
        always_ff @(posedge clk) begin
          if (rst) q <= '0;
          else if (enable) q <= tap[m];
        end
        assign tap[m+1] = q;
      end
      assign deskewed[j] = tap[L];
    end
  end

`ifdef MMU_OUTPUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) result <= '0;
    else if (enable) result <= deskewed;
  end
`else
  assign result = deskewed;
`endif

endmodule

// File: tb/tb_mmu_systolic_array.sv
// Directed self-checking bench for mmu_systolic_array at N=4 with hand-computed result rows.
module tb_mmu_systolic_array;
  localparam int N   = 4;
  localparam int LAT = 2 * N - 3;

  logic clk = 1'b0;
  logic rst, en, wsg, ldw, act, ssg;
  logic [7:0] waddr;
  logic [N-1:0][7:0]  wd, sd;
  logic [N-1:0][31:0] res;

  int total = 0;
  int bad   = 0;

  int XU [4][4] = '{'{40,76,19,192}, '{3,84,12,8}, '{54,18,255,120}, '{30,84,122,2}};
  int WU [4][4] = '{'{13,89,178,9}, '{84,184,245,18}, '{255,73,14,3}, '{98,212,78,29}};
  int RU [4][4] = '{'{30565,59635,40982,7353}, '{10939,18295,21906,1807},
                    '{78999,52173,26952,5055}, '{38752,27456,27784,2206}};
  int XS [4][4] = '{'{74,91,64,10}, '{5,28,26,9}, '{56,9,72,127}, '{94,26,92,8}};
  int WS [4][4] = '{'{-13,89,92,9}, '{-84,104,86,18}, '{-128,73,14,3}, '{-98,127,78,29}};
  int RS [4][4] = '{'{-17778,21992,16310,2786}, '{-6627,6398,3934,888},
                    '{-23146,27305,16840,4565}, '{-15966,18802,12796,1822}};
  // x = {-1,0,0,2} signed: -W_S row 0 + 2*W_S row 3
  int XNEG [4] = '{-1, 0, 0, 2};
  int RNEG [4] = '{-183, 165, 64, 49};

  int vx   [8][4];
  int vexp [8][4];

  mmu_systolic_array #(.MATRIX_WIDTH(N)) dut (
    .clk(clk), .rst(rst), .enable(en),
    .weight_data(wd), .weight_signed(wsg), .weight_addr(waddr),
    .load_weight(ldw), .activate_weight(act),
    .systolic_data(sd), .systolic_signed(ssg),
    .result(res)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic chk_row(input string tag, input int r);
    for (int j = 0; j < N; j++)
      check($sformatf("%s v%0d col%0d", tag, r, j), res[j], 32'(vexp[r][j]));
  endtask

  task automatic idle();
    sd = '0; act = 1'b0; ldw = 1'b0; wsg = 1'b0; waddr = '0; wd = '0; en = 1'b1;
  endtask

  task automatic load_w(input bit use_ws, input bit sg);
    en = 1'b0; ldw = 1'b1; wsg = sg;
    for (int r = 0; r < N; r++) begin
      waddr = 8'(r);
      for (int j = 0; j < N; j++) wd[j] = 8'(use_ws ? WS[r][j] : WU[r][j]);
      step();
    end
    waddr = 8'd4;
    for (int j = 0; j < N; j++) wd[j] = 8'(j + 1);
    step();
    idle();
  endtask

  task automatic run(input int nv, input bit act0, input int act2_c, input int ld_c,
                     input int stall_at, input int stall_len, input int rst_c, input string tag);
    int r;
    for (int c = 0; c <= nv + 2 * N - 4; c++) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = c - k;
        sd[k] = (i >= 0 && i < nv) ? 8'(vx[i][k]) : 8'd0;
      end
      act = (act0 && c == 0) || (c == act2_c);
      if (ld_c >= 0 && c >= ld_c && c < ld_c + N) begin
        ldw = 1'b1; wsg = 1'b1; waddr = 8'(c - ld_c);
        for (int j = 0; j < N; j++) wd[j] = 8'(WS[c - ld_c][j]);
      end else begin
        ldw = 1'b0;
      end
      if (c == stall_at) begin
        en = 1'b0;
        repeat (stall_len) begin
          step();
          r = c - 1 - LAT;
          if (r >= 0 && r < nv) chk_row({tag, "_hold"}, r);
        end
        en = 1'b1;
      end
      if (c == rst_c) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int j = 0; j < N; j++) check($sformatf("%s col%0d", tag, j), res[j], 32'd0);
        idle();
        return;
      end
      step();
      r = c - LAT;
      if (r >= 0 && r < nv) chk_row(tag, r);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1; ssg = 1'b0;
    idle();
    en = 1'b0;
    repeat (2) step();
    for (int j = 0; j < N; j++) check($sformatf("reset col%0d", j), res[j], 32'd0);
    rst = 1'b0;
    idle();

    load_w(1'b0, 1'b0);
    ssg = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < N; k++) begin vx[i][k] = XU[i][k]; vexp[i][k] = RU[i][k]; end
    run(4, 1'b1, -1, -1, -1, 0, -1, "unsigned");
    run(4, 1'b1, -1, -1, 6, 3, -1, "stall");

    load_w(1'b1, 1'b1);
    ssg = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < N; k++) begin vx[i][k] = XS[i][k]; vexp[i][k] = RS[i][k]; end
    for (int k = 0; k < N; k++) begin vx[4][k] = XNEG[k]; vexp[4][k] = RNEG[k]; end
    run(5, 1'b1, -1, -1, -1, 0, -1, "signed");

    // Activate W_U, reload W_S from the activation edge onward, activate again at c=6
    load_w(1'b0, 1'b0);
    ssg = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 4; i++) begin vx[i][k] = XU[i][k]; vexp[i][k] = RU[i][k]; end
      for (int i = 4; i < 6; i++) begin vx[i][k] = 0; vexp[i][k] = 0; end
      for (int i = 6; i < 8; i++) begin vx[i][k] = XS[i-6][k]; vexp[i][k] = RS[i-6][k]; end
    end
    run(8, 1'b1, 6, 0, -1, 0, -1, "dbuf");

    load_w(1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < N; k++) begin vx[i][k] = XU[i][k]; vexp[i][k] = RU[i][k]; end
    run(4, 1'b1, -1, -1, -1, 0, 3, "rst_mid");
    for (int k = 0; k < N; k++) begin vx[0][k] = XU[0][k]; vexp[0][k] = 0; end
    run(1, 1'b0, -1, -1, -1, 0, -1, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
